mdu_sched: RTL and testbench

- Sequencer for the multiply/divide unit and HI/LO registers in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu issued from the E stage and holds HI/LO writes for a fixed latency.
- Commits results to HI/LO at the end of that latency.
- Generates the D-stage stall for any MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while the unit is occupied.

---
 rtl/mdu_sched_pkg.sv | 25 ++
 rtl/mdu_calc.sv | 73 +++++++
 rtl/mdu_sched.sv | 147 ++++++++++++++
 tb/tb_mdu_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sched_pkg
// Purpose  : Shared encodings for the multiply/divide sequencer: md_op codes,
//            FSM state codes and default busy-cycle counts.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_sched_pkg;

    // md_op encodings; bit 1 selects divide, bit 0 selects unsigned
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Default busy-cycle counts
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage : mdu_sched_pkg
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module   : mdu_calc
// Purpose  : Purely combinational 64-bit multiply / divide result generator.
// Ports    : a, b     - 32-bit operands (a = multiplicand/dividend)
//            op       - md_op code
//            res_hi   - HI result (product high word / remainder)
//            res_lo   - LO result (product low word / quotient)
//            div0     - divide operation with a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module mdu_calc
    import mdu_sched_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    always_comb begin
        w_signed = (op == MD_MULT) || (op == MD_DIV);
        w_a_neg  = w_signed & a[31];
        w_b_neg  = w_signed & b[31];

        // Sign/zero extension to 64 bits makes an unsigned 64x64 multiply
        // produce the correct low 64 bits for both signed and unsigned ops.
        w_a64  = w_signed ? {{32{a[31]}}, a} : {32'd0, a};
        w_b64  = w_signed ? {{32{b[31]}}, b} : {32'd0, b};
        w_prod = w_a64 * w_b64;

        // Signed divide is done on magnitudes, then signs are reapplied:
        // quotient truncates toward zero, remainder follows the dividend.
        // 0x80000000 / -1 falls out naturally as quotient 0x80000000, rem 0.
        w_a_mag  = w_a_neg ? (~a + 32'd1) : a;
        w_b_mag  = w_b_neg ? (~b + 32'd1) : b;
        // Zero divisor is replaced to keep the divider well-defined; the
        // result is discarded at commit anyway.
        w_b_safe = (b == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_b_safe;
        w_r_mag  = w_a_mag % w_b_safe;
        w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

        div0 = op[1] && (b == 32'd0);

        if (op[1]) begin
            res_hi = w_rem;
            res_lo = w_quot;
        end else begin
            res_hi = w_prod[63:32];
            res_lo = w_prod[31:0];
        end
    end

endmodule : mdu_calc
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sched
// Purpose  : Multiply/divide sequencer with HI/LO registers for a 5-stage
//            MIPS pipeline. Latches the result at issue, holds it for a fixed
//            latency, then commits to HI/LO. Raises the D-stage stall for
//            MD-class instructions while the unit is occupied.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start, md_op        - E-stage mult/div issue and its opcode
//            rs_val, rt_val      - operands (also mthi/mtlo source = rs_val)
//            mthi, mtlo          - E-stage HI/LO writes
//            d_uses_md           - D-stage instruction is MD-class
//            irq_flush           - cancels the E-stage instruction
//            busy, stall         - unit occupied / D-stage stall request
//            hi, lo              - architectural HI/LO
// Config   : MDU_FLUSH_ABORT_EN  - when defined, irq_flush during RUN aborts
//                                  the operation without committing.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        d_uses_md,
    input  logic        irq_flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Counter holds at most N-1
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_load;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_div0;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_calc_hi;
    logic [31:0]        w_calc_lo;
    logic               w_calc_div0;
    logic               w_start_ok;
    logic               w_abort;
    logic               w_load;
    logic               w_commit;
    logic               w_mt_ok;

    mdu_calc u_calc (
        .a      (rs_val),
        .b      (rt_val),
        .op     (md_op),
        .res_hi (w_calc_hi),
        .res_lo (w_calc_lo),
        .div0   (w_calc_div0)
    );

    assign w_start_ok = start && !irq_flush;
    assign w_cnt_load = md_op[1] ? c_cnt_w'(DIV_CYCLES - 1) : c_cnt_w'(MULT_CYCLES - 1);

`ifdef MDU_FLUSH_ABORT_EN
    assign w_abort = (r_state == S_RUN) && irq_flush;
`else
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:  if (w_abort || (r_cnt == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (r_state == S_RUN);
        w_load   = (r_state == S_IDLE) && w_start_ok;
        w_commit = (r_state == S_RUN) && (r_cnt == '0) && !w_abort;
        // mthi/mtlo only land when the unit is idle and no op issues alongside
        w_mt_ok  = (r_state == S_IDLE) && !start && !irq_flush;
    end

    assign stall = d_uses_md && (busy || w_start_ok);

    // Datapath: counter, pending result and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            if (w_load) begin
                r_cnt    <= w_cnt_load;
                r_res_hi <= w_calc_hi;
                r_res_lo <= w_calc_lo;
                r_div0   <= w_calc_div0;
            end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end

            // Divide-by-zero runs the full latency but leaves HI/LO alone
            if (w_commit && !r_div0) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end else if (w_mt_ok) begin
                if (mthi) r_hi <= rs_val;
                if (mtlo) r_lo <= rs_val;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : mdu_sched
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sched
// Purpose  : Directed self-checking bench for mdu_sched with hand-computed
//            expected HI/LO values and cycle-exact busy/stall checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic        d_uses_md;
    logic        irq_flush;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    always #5 clk = ~clk;

    mdu_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .d_uses_md (d_uses_md),
        .irq_flush (irq_flush),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check busy/stall/HI/LO every busy cycle and the commit.
    // With mt_in_run set, mthi/mtlo are held high during RUN to prove they
    // are ignored.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic mt_in_run,
                          input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_uses_md = 1'b1;
        #1 check({tag, "_stall_issue"}, 64'(stall), 64'd1);
        tick();
        start = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'd0;
        mthi = mt_in_run; mtlo = mt_in_run;
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_busy"},  64'(busy),  64'd1);
            check({tag, "_stall"}, 64'(stall), 64'd1);
            check({tag, "_hi_hold"}, 64'(hi), 64'(m_hi));
            check({tag, "_lo_hold"}, 64'(lo), 64'(m_lo));
            tick();
        end
        #1;
        check({tag, "_busy_done"},  64'(busy),  64'd0);
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        mthi = 1'b0; mtlo = 1'b0; d_uses_md = 1'b0;
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; d_uses_md = 1'b0; irq_flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hi",    64'(hi),    64'd0);
        check("rst_lo",    64'(lo),    64'd0);

        // -2 * 3 = -6
        run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        // 100 / 7 = 14 r 2
        run_op("divu", 2'b11, 32'd100, 32'd7, 10, 1'b0, 32'd2, 32'd14);
        // -7 / 2 = -3 r -1, with mthi/mtlo held during RUN
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        // Overflow case
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);

        // mthi / mtlo in IDLE
        mthi = 1'b1; rs_val = 32'h1234;
        tick();
        mthi = 1'b0;
        check("mthi", 64'(hi), 64'h1234);
        check("mthi_lo_keep", 64'(lo), 64'h8000_0000);
        mthi = 1'b1; rs_val = 32'hA; tick();
        mthi = 1'b0; mtlo = 1'b1; rs_val = 32'hB; tick();
        mtlo = 1'b0;
        check("mt_hi_a", 64'(hi), 64'hA);
        check("mt_lo_b", 64'(lo), 64'hB);
        m_hi = 32'hA; m_lo = 32'hB;

        // mthi with irq_flush is dropped
        mthi = 1'b1; irq_flush = 1'b1; rs_val = 32'h5555; tick();
        mthi = 1'b0; irq_flush = 1'b0;
        check("mthi_flush", 64'(hi), 64'hA);

        // Divide by zero leaves HI/LO untouched after full latency
        run_op("div0", 2'b10, 32'd50, 32'd0, 10, 1'b0, 32'hA, 32'hB);

        // start with irq_flush: ignored
        start = 1'b1; irq_flush = 1'b1; md_op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
        d_uses_md = 1'b1;
        #1 check("flush_start_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0; irq_flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        d_uses_md = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("flush_start_hi", 64'(hi), 64'hA);
        check("flush_start_lo", 64'(lo), 64'hB);

        // irq_flush during RUN: 7 * 6 = 42, flush after start edge + 2
        start = 1'b1; md_op = 2'b00; rs_val = 32'd7; rt_val = 32'd6;
        tick();
        start = 1'b0;
        tick();
        irq_flush = 1'b1;
        tick();
        irq_flush = 1'b0;
`ifdef MDU_FLUSH_ABORT_EN
        check("flush_run_busy", 64'(busy), 64'd0);
        tick(); tick(); tick();
        check("flush_run_hi", 64'(hi), 64'hA);
        check("flush_run_lo", 64'(lo), 64'hB);
`else
        check("flush_run_busy", 64'(busy), 64'd1);
        tick(); tick(); tick();
        check("flush_run_done", 64'(busy), 64'd0);
        check("flush_run_hi", 64'(hi), 64'd0);
        check("flush_run_lo", 64'(lo), 64'd42);
`endif

        // Reset at cycle 3 of a mult abandons it
        start = 1'b1; md_op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi",   64'(hi),   64'd0);
        check("rst_mid_lo",   64'(lo),   64'd0);
        tick(); tick(); tick(); tick(); tick();
        check("rst_mid_nocommit", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mdu_sched
`default_nettype wire
